execute_stage_module: RTL and testbench
=======================================

Name: execute_stage_module

Overview:
- Execute (EX) stage of the 5-stage RV32I pipeline. No hazard control. Sits directly downstream of the decode stage's ID/EX register.
- Selects ALU operand B, runs the ALU, and resolves the branch (taken/target) combinationally back to fetch.
- Registers the results and control into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width for operands, PC and results.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RegWriteE  in  1  register-file write enable of the EX instruction
- ResultSrcE  in  1  writeback select: 0 = ALU result, 1 = load data
- MemWriteE  in  1  data-memory write enable
- BranchE  in  1  instruction is a conditional branch (beq)
- ALUSrcE  in  1  operand B select: 0 = RD2_E, 1 = ImmExtE
- ALUControlE  in  3  ALU operation
- RD1_E  in  XLEN  rs1 value (operand A)
- RD2_E  in  XLEN  rs2 value
- ImmExtE  in  XLEN  sign-extended immediate
- PCE  in  XLEN  PC of the EX instruction
- RdE  in  5  destination register
- PCPlus4E  in  XLEN  PC+4 of the EX instruction
- PCSrcE  out  1  branch taken, combinational, to fetch
- PCTargetE  out  XLEN  branch target, combinational, to fetch
- RegWriteM  out  1  registered RegWriteE
- ResultSrcM  out  1  registered ResultSrcE
- MemWriteM  out  1  registered MemWriteE
- ALUResultM  out  XLEN  registered ALU result
- WriteDataM  out  XLEN  registered RD2_E (store data)
- RdM  out  5  registered RdE
- PCPlus4M  out  XLEN  registered PCPlus4E

Behaviour:
- Operand B: SrcBE = ALUSrcE ? ImmExtE : RD2_E.
- ALU operations (ALUControlE):
  - 000 add: A+B, modulo 2^XLEN, overflow ignored.
  - 001 sub: A-B, modulo 2^XLEN.
  - 010 and.
  - 011 or.
  - 101 slt: see Optional Feature.
  - 100, 110, 111: result all zero.
- ZeroE = (ALUResult == 0), internal only.
- PCSrcE = BranchE & ZeroE. Combinational, zero-cycle latency, also valid during reset.
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN. Computed regardless of BranchE.
- EX/MEM register:
  - All M outputs update on the rising clk edge from the current E inputs and ALU result. Latency 1 cycle.
  - No stall or flush input: the register captures every cycle.
- WriteDataM always takes RD2_E, never SrcBE, even when ALUSrcE=1.
- Reset: rst low asynchronously forces every M output to 0 (1-bit outputs 0, RdM 5'h00, XLEN outputs all zeros) and holds them while low.
- First rising edge after rst deasserts captures the inputs normally.
- Reset mid-operation discards the in-flight instruction. There is no replay.
- PCSrcE and PCTargetE are not reset; they follow the inputs. Upstream reset drives BranchE=0, so PCSrcE=0.
- Branch with ALUControlE≠001: the zero flag is still taken from whatever op is selected. No special casing.

Optional Feature:
- Macro: EXECUTE_SLT_EN.
- Defined: ALUControlE=101 yields a signed compare, ALUResult = {XLEN-1 zeros, ($signed(A) < $signed(SrcB))}. The result is derived from subtraction sign xor overflow.
- Undefined: 101 is treated like the other unused codes and the result is all zero. No other behaviour changes.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - XLEN default.
  - Reset value constant for zeroed datapath registers.
- One sub-module: alu_module (inputs A, B, ALUControl; outputs Result, Zero). It is purely combinational and instanced once.
- Operand mux, target adder and EX/MEM register stay in execute_stage_module.

Test Plan:
- Reset: hold rst=0 with random inputs, then pulse clk → all M outputs 0 both before and after the clock edge. Then release rst, apply RegWriteE=1, RdE=5 → RegWriteM=1, RdM=5 one edge later.
- add immediate: RD1_E=0x10, ImmExtE=0xFFFFFFFC, ALUSrcE=1, ALUControlE=000, RD2_E=0xAA → after one edge ALUResultM=0x0C, WriteDataM=0xAA.
- Register sub wrap: RD1_E=0, RD2_E=1, ALUSrcE=0, ALUControlE=001 → ALUResultM=0xFFFFFFFF.
- beq taken: BranchE=1, RD1_E=RD2_E=0x1234, ALUControlE=001, PCE=0x100, ImmExtE=0xFFFFFFF0 → same cycle PCSrcE=1, PCTargetE=0xF0. With RD2_E=0x1235 → PCSrcE=0 and PCTargetE still 0xF0.
- slt: RD1_E=0xFFFFFFFF, RD2_E=1, ALUControlE=101 → ALUResultM=1 with EXECUTE_SLT_EN defined, 0 without.
- Async reset mid-stream: stream add ops, assert rst between clock edges → M outputs go to 0 immediately, not at the next edge.

Source files
------------

// File: rtl/execute_stage_module_pkg.sv
// rtl/execute_stage_module_pkg.sv - shared constants for the RV32I execute stage
// Purpose: ALU operation encodings, default datapath width and the reset
//          value used for zeroed EX/MEM datapath registers.
// Ports:   none (package).
package execute_stage_module_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [XLEN_DEFAULT-1:0] RST_DATA = '0;

endpackage

// File: rtl/execute_stage_module_if.sv
// rtl/execute_stage_module_if.sv - ID/EX inputs, branch resolution and EX/MEM outputs of the execute stage
// Purpose: bundles every non-clock/reset signal of the execute stage.
// Ports:   E-suffixed signals come from the ID/EX register; PCSrcE/PCTargetE
//          go back to fetch; M-suffixed signals feed the memory stage.
//          master = upstream/downstream environment, slave = execute stage.
interface execute_stage_module_if
    import execute_stage_module_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            RegWriteE;
    logic            ResultSrcE;
    logic            MemWriteE;
    logic            BranchE;
    logic            ALUSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [4:0]      RdE;
    logic [XLEN-1:0] PCPlus4E;

    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;

    logic            RegWriteM;
    logic            ResultSrcM;
    logic            MemWriteM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [4:0]      RdM;
    logic [XLEN-1:0] PCPlus4M;

    modport master (
        output RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
               RD1_E, RD2_E, ImmExtE, PCE, RdE, PCPlus4E,
        input  PCSrcE, PCTargetE,
               RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
               RD1_E, RD2_E, ImmExtE, PCE, RdE, PCPlus4E,
        output PCSrcE, PCTargetE,
               RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M
    );
endinterface

// File: rtl/execute_stage_module_alu.sv
// rtl/execute_stage_module_alu.sv - combinational RV32I ALU (alu_module)
// Purpose: add/sub/and/or and, when EXECUTE_SLT_EN is defined, signed set-less-than.
//          Unused encodings (and 101 without EXECUTE_SLT_EN) produce zero.
// Ports:   A, B operands; ALUControl operation; Result; Zero = (Result == 0).
module alu_module
    import execute_stage_module_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);
    logic [XLEN-1:0] w_diff;

    assign w_diff = A - B;

`ifdef EXECUTE_SLT_EN
    // Signed less-than = sign of (A-B) corrected by two's-complement overflow:
    // overflow happens only when the operand signs differ and the difference's
    // sign disagrees with A.
    logic w_overflow;
    logic w_lt;

    assign w_overflow = (A[XLEN-1] ^ B[XLEN-1]) & (w_diff[XLEN-1] ^ A[XLEN-1]);
    assign w_lt       = w_diff[XLEN-1] ^ w_overflow;
`endif

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = w_diff;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
`ifdef EXECUTE_SLT_EN
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, w_lt};
`endif
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);
endmodule

// File: rtl/execute_stage_module.sv
// rtl/execute_stage_module.sv - RV32I execute stage with EX/MEM pipeline register
// Purpose: selects ALU operand B, runs the ALU, resolves beq back to fetch
//          combinationally and registers results/control into EX/MEM.
//          Optional macro EXECUTE_SLT_EN enables signed slt (ALUControlE=101).
// Ports:   clk  - rising-edge pipeline clock
//          rst  - asynchronous active-low reset, clears every M output
//          bus  - execute_stage_module_if.slave (E inputs, PCSrcE/PCTargetE, M outputs)
module execute_stage_module
    import execute_stage_module_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    execute_stage_module_if.slave bus
);
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_zero;

    logic            r_reg_write;
    logic            r_result_src;
    logic            r_mem_write;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_write_data;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_pc_plus4;

    assign w_src_b = bus.ALUSrcE ? bus.ImmExtE : bus.RD2_E;

    alu_module #(.XLEN(XLEN)) u_alu (
        .A          (bus.RD1_E),
        .B          (w_src_b),
        .ALUControl (bus.ALUControlE),
        .Result     (w_alu_result),
        .Zero       (w_zero)
    );

    // Branch resolution is not reset: it tracks the inputs, and upstream reset
    // holds BranchE low so PCSrcE stays low while the pipeline is in reset.
    assign bus.PCSrcE    = bus.BranchE & w_zero;
    assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

    // EX/MEM register captures every cycle; no stall or flush.
    // Store data is always rs2, even for immediate-operand instructions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_result <= RST_DATA[XLEN-1:0];
            r_write_data <= RST_DATA[XLEN-1:0];
            r_rd         <= 5'h00;
            r_pc_plus4   <= RST_DATA[XLEN-1:0];
        end else begin
            r_reg_write  <= bus.RegWriteE;
            r_result_src <= bus.ResultSrcE;
            r_mem_write  <= bus.MemWriteE;
            r_alu_result <= w_alu_result;
            r_write_data <= bus.RD2_E;
            r_rd         <= bus.RdE;
            r_pc_plus4   <= bus.PCPlus4E;
        end
    end

    assign bus.RegWriteM  = r_reg_write;
    assign bus.ResultSrcM = r_result_src;
    assign bus.MemWriteM  = r_mem_write;
    assign bus.ALUResultM = r_alu_result;
    assign bus.WriteDataM = r_write_data;
    assign bus.RdM        = r_rd;
    assign bus.PCPlus4M   = r_pc_plus4;
endmodule

// File: tb/tb_execute_stage_module.sv
// tb/tb_execute_stage_module.sv - self-checking bench for execute_stage_module
module tb_execute_stage_module;
    typedef struct packed {
        logic        regw;
        logic        rsrc;
        logic        memw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } m_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    m_t   sb[$];

    execute_stage_module_if #(.XLEN(32)) bus ();

    execute_stage_module #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
`ifdef EXECUTE_SLT_EN
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic m_t get_m();
        m_t m;
        m.regw = bus.RegWriteM;
        m.rsrc = bus.ResultSrcM;
        m.memw = bus.MemWriteM;
        m.alu  = bus.ALUResultM;
        m.wd   = bus.WriteDataM;
        m.rd   = bus.RdM;
        m.pc4  = bus.PCPlus4M;
        return m;
    endfunction

    // Drives one instruction and pushes its expected EX/MEM contents.
    task automatic drive(input logic regw, input logic rsrc, input logic memw, input logic br,
                         input logic alusrc, input logic [2:0] op, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rd);
        m_t e;
        bus.RegWriteE   = regw;
        bus.ResultSrcE  = rsrc;
        bus.MemWriteE   = memw;
        bus.BranchE     = br;
        bus.ALUSrcE     = alusrc;
        bus.ALUControlE = op;
        bus.RD1_E       = rd1;
        bus.RD2_E       = rd2;
        bus.ImmExtE     = imm;
        bus.PCE         = pc;
        bus.RdE         = rd;
        bus.PCPlus4E    = pc + 32'd4;
        e.regw = regw;
        e.rsrc = rsrc;
        e.memw = memw;
        e.alu  = alu_ref(rd1, alusrc ? imm : rd2, op);
        e.wd   = rd2;
        e.rd   = rd;
        e.pc4  = pc + 32'd4;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        m_t obs;
        m_t e;
        rst = 1'b0;
        bus.RegWriteE   = 1'b1;
        bus.ResultSrcE  = 1'b1;
        bus.MemWriteE   = 1'b1;
        bus.BranchE     = 1'b0;
        bus.ALUSrcE     = 1'b0;
        bus.ALUControlE = 3'd0;
        bus.RD1_E       = $urandom;
        bus.RD2_E       = $urandom;
        bus.ImmExtE     = $urandom;
        bus.PCE         = $urandom;
        bus.RdE         = 5'h1f;
        bus.PCPlus4E    = $urandom;
        #1;
        obs = get_m();
        n_total++;
        if (obs !== '0) $display("FAIL reset_before_edge: got %h expected 0", obs);
        else n_pass++;
        n_total++;
        if (bus.PCTargetE !== bus.PCE + bus.ImmExtE || bus.PCSrcE !== 1'b0)
            $display("FAIL reset_branch_outputs: got %b/%h expected 0/%h", bus.PCSrcE, bus.PCTargetE, bus.PCE + bus.ImmExtE);
        else n_pass++;
        @(posedge clk); #1;
        obs = get_m();
        n_total++;
        if (obs !== '0) $display("FAIL reset_after_edge: got %h expected 0", obs);
        else n_pass++;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd5);
        @(posedge clk); #1;
        e = sb.pop_front();
        obs = get_m();
        n_total++;
        if (obs.regw !== 1'b1 || obs.rd !== 5'd5 || obs !== e)
            $display("FAIL reset_release: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_add_imm();
        m_t obs;
        m_t e;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h10, 32'hAA, 32'hFFFF_FFFC, 32'h40, 5'd3);
        @(posedge clk); #1;
        e = sb.pop_front();
        obs = get_m();
        n_total++;
        if (obs.alu !== 32'h0C || obs.wd !== 32'hAA)
            $display("FAIL add_imm: got alu=%h wd=%h expected alu=0000000c wd=000000aa", obs.alu, obs.wd);
        else n_pass++;
        n_total++;
        if (obs !== e) $display("FAIL add_imm_all: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_sub_wrap();
        m_t obs;
        m_t e;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd0, 32'd1, 32'h7, 32'h80, 5'd9);
        @(posedge clk); #1;
        e = sb.pop_front();
        obs = get_m();
        n_total++;
        if (obs.alu !== 32'hFFFF_FFFF) $display("FAIL sub_wrap: got %h expected ffffffff", obs.alu);
        else n_pass++;
        n_total++;
        if (obs !== e) $display("FAIL sub_wrap_all: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_branch();
        m_t e;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h1234, 32'h1234, 32'hFFFF_FFF0, 32'h100, 5'd0);
        #1;
        n_total++;
        if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'hF0)
            $display("FAIL beq_taken: got %b/%h expected 1/000000f0", bus.PCSrcE, bus.PCTargetE);
        else n_pass++;
        bus.RD2_E = 32'h1235;
        #1;
        n_total++;
        if (bus.PCSrcE !== 1'b0 || bus.PCTargetE !== 32'hF0)
            $display("FAIL beq_not_taken: got %b/%h expected 0/000000f0", bus.PCSrcE, bus.PCTargetE);
        else n_pass++;
        // The queued entry reflects the first operands; discard it and redo the
        // register check against the operands actually present at the edge.
        void'(sb.pop_front());
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h1234, 32'h1235, 32'hFFFF_FFF0, 32'h100, 5'd0);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_total++;
        if (get_m() !== e) $display("FAIL beq_reg: got %h expected %h", get_m(), e);
        else n_pass++;
    endtask

    task automatic test_slt();
        m_t obs;
        m_t e;
        logic [31:0] want;
`ifdef EXECUTE_SLT_EN
        want = 32'd1;
`else
        want = 32'd0;
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h200, 5'd7);
        @(posedge clk); #1;
        e = sb.pop_front();
        obs = get_m();
        n_total++;
        if (obs.alu !== want) $display("FAIL slt: got %h expected %h", obs.alu, want);
        else n_pass++;
        n_total++;
        if (obs !== e) $display("FAIL slt_all: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        m_t obs;
        m_t e;
        logic [31:0] a, b, imm, pc;
        logic [2:0] op;
        logic alusrc, br, exp_src;
        for (int i = 0; i < 40; i++) begin
            a      = $urandom;
            b      = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc     = $urandom;
            op     = 3'($urandom_range(0, 7));
            alusrc = 1'($urandom_range(0, 1));
            br     = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  br, alusrc, op, a, b, imm, pc, 5'($urandom_range(0, 31)));
            exp_src = br & (alu_ref(a, alusrc ? imm : b, op) == 32'd0);
            #1;
            n_total++;
            if (bus.PCSrcE !== exp_src || bus.PCTargetE !== pc + imm)
                $display("FAIL b2b_branch[%0d]: got %b/%h expected %b/%h", i, bus.PCSrcE, bus.PCTargetE, exp_src, pc + imm);
            else n_pass++;
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = get_m();
            n_total++;
            if (obs !== e) $display("FAIL b2b_reg[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        m_t obs;
        m_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h100 + i, 32'h20, 32'd0, 32'h300, 5'(i + 1));
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = get_m();
            n_total++;
            if (obs !== e) $display("FAIL stream[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
        #2;
        rst = 1'b0;
        #1;
        obs = get_m();
        n_total++;
        if (obs !== '0) $display("FAIL async_reset: got %h expected 0", obs);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'hF0, 32'h0F, 32'd0, 32'h400, 5'd12);
        @(posedge clk); #1;
        e = sb.pop_front();
        obs = get_m();
        n_total++;
        if (obs !== e) $display("FAIL after_async_reset: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_sub_wrap();
        test_branch();
        test_slt();
        test_back_to_back();
        test_async_reset();
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
